uart_echo_host: RTL
===================

// Module: uart_echo_host
// PURPOSE
//  Register-bus initiator for the uart core: drives enable/write_enable/address/write_data and samples read_data.
//  On go, programs CTRL and CTRL_INT; thereafter loops: wait for rx_data_int, read RECEIVE,
//  write SEND, pulse TX_START, wait for tx_done_int.
//  Sits beside one uart instance as its autonomous host (echo/loopback service).
// PARAMETERS
//  BAUD_SEL     3'b100  CTRL[5:3] baud select (100 = 115200)
//  BIT_SIZE     3'b100  CTRL[2:0] bit size (100 = 8 bits)
//  ACCESS_CYC   2       clocks each bus access is held (>=2)
//  TX_TIMEOUT   4095    clocks to wait for tx_done_int before abort (12-bit counter)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous reset, active low
//  go            in   1  pulse: configure uart, enter echo loop (ignored unless IDLE)
//  stop          in   1  pulse: finish current access, return to IDLE
//  enable        out  1  uart bus enable
//  write_enable  out  1  1 = write, 0 = read
//  address       out  3  0 CTRL, 1 CTRL_INT, 2 SEND, 3 RECEIVE
//  write_data    out  8  write payload
//  read_data     in   8  uart read data
//  rx_data_int   in   1  uart receive-done interrupt
//  tx_done_int   in   1  uart transmit-done interrupt
//  rx_error_int  in   1  uart receive-error interrupt
//  busy          out  1  FSM not IDLE
//  echo_count    out  8  bytes echoed, wraps 255->0
//  err_count     out  8  rx_error_int rising edges, saturates at 255
//  overrun       out  1  sticky: rx edge while one already pending; cleared by go
//  timeout       out  1  sticky: TX_TIMEOUT expired; cleared by go
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, pending 0.
//  Access: address/write_data/write_enable/enable driven together, held ACCESS_CYC clocks; read_data sampled on last held clock.
//  Between accesses enable=0 for exactly 1 clock.
//  FSM: IDLE -go-> CFG_CTRL (wr 0, {1'b0,1'b1,BAUD_SEL,BIT_SIZE}) -> CFG_INT (wr 1, 8'b1110_0000)
//   -> WAIT_RX -> RD_RX (rd 3, latch byte) -> WR_SEND (wr 2, byte) -> START (wr 0, TX_START=1)
//   -> CLR_START (wr 0, TX_START=0) -> WAIT_TX -tx_done_int rise-> echo_count+1 -> WAIT_RX.
//  Interrupt inputs edge-detected (registered previous value); a rise counts once regardless of width.
//  rx rise in any state sets pending; WAIT_RX leaves to RD_RX when pending (cleared on RD_RX entry).
//  rx rise while pending=1 sets overrun; byte dropped, pending stays 1.
//  rx_error_int rise: err_count+1 (sat); the associated byte is still echoed if rx_data_int also rises.
//  WAIT_TX counter exceeds TX_TIMEOUT: timeout=1, go to WAIT_RX, echo_count unchanged.
//  stop: honoured only at access boundary or in WAIT_RX/WAIT_TX; goes IDLE, uart config left untouched.
//  stop and go same cycle: stop wins. go while busy: ignored.
//  rst low mid-access: outputs drop to 0 asynchronously; no partial-write recovery.
// CONFIGURATION
//  UART_ECHO_UPCASE_EN defined: byte in 8'h61..8'h7A gets bit5 cleared before WR_SEND (a->A); others unchanged.
//  Undefined: byte echoed verbatim. Counters/FSM identical in both builds.
// TESTING
//  (10 MHz clk, 87 clk/bit, DUT wired to uart, partner uart on rx/tx)
//  go pulse -> CTRL write 8'h64, then CTRL_INT 8'hE0, each enable high 2 clks, 1-clk gap; busy=1.
//  Partner sends 8'hAB -> partner receives 8'hAB within 12 bit periods; echo_count=1.
//  UART_ECHO_UPCASE_EN: send 8'h61 -> 8'h41 echoed; send 8'h5A -> 8'h5A echoed.
//  Two bytes back-to-back while echoing first, third rise before read -> overrun=1, echo_count=2.
//  Partner byte with bad stop bit -> err_count=1; tx_done_int held 0 -> timeout=1 after 4096 clks.
//  rst low during SEND write -> all outputs 0 same cycle; after release, go restarts at CFG_CTRL.

Source files
------------

// File: rtl/uart_echo_host.sv
// uart_echo_host: autonomous register-bus host for one uart instance.
// After a go pulse it programs CTRL and CTRL_INT. It then echoes every received
// byte: read RECEIVE, write SEND, pulse TX_START, wait for the transmit-done interrupt.
// Optional build macro UART_ECHO_UPCASE_EN: lower-case ASCII bytes are echoed upper-cased.
`timescale 1ns/1ps
module uart_echo_host #(
  parameter logic [2:0]  BAUD_SEL   = 3'b100,
  parameter logic [2:0]  BIT_SIZE   = 3'b100,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned TX_TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       stop,
  output logic       enable,
  output logic       write_enable,
  output logic [2:0] address,
  output logic [7:0] write_data,
  input  logic [7:0] read_data,
  input  logic       rx_data_int,
  input  logic       tx_done_int,
  input  logic       rx_error_int,
  output logic       busy,
  output logic [7:0] echo_count,
  output logic [7:0] err_count,
  output logic       overrun,
  output logic       timeout
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_CFG_CTRL  = 4'd1;
  localparam logic [3:0] ST_CFG_INT   = 4'd2;
  localparam logic [3:0] ST_WAIT_RX   = 4'd3;
  localparam logic [3:0] ST_RD_RX     = 4'd4;
  localparam logic [3:0] ST_WR_SEND   = 4'd5;
  localparam logic [3:0] ST_START     = 4'd6;
  localparam logic [3:0] ST_CLR_START = 4'd7;
  localparam logic [3:0] ST_WAIT_TX   = 4'd8;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_CTRL_IN = 3'd1;
  localparam logic [2:0] A_SEND    = 3'd2;
  localparam logic [2:0] A_RECV    = 3'd3;

  localparam logic [7:0] CTRL_CFG   = {1'b0, 1'b1, BAUD_SEL, BIT_SIZE};
  localparam logic [7:0] CTRL_START = {1'b1, 1'b1, BAUD_SEL, BIT_SIZE};
  localparam logic [7:0] INT_CFG    = 8'hE0;

  // Access counter: 0..ACC_LAST drive the bus, ACC_GAP is the idle gap clock.
  localparam logic [11:0] ACC_LAST = 12'(ACCESS_CYC - 1);
  localparam logic [11:0] ACC_GAP  = 12'(ACCESS_CYC);
  localparam logic [11:0] TMO_LIM  = 12'(TX_TIMEOUT);

  logic [3:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  echo_q, echo_d;
  logic [7:0]  errc_q, errc_d;
  logic        pending_q, pending_d;
  logic        stop_req_q, stop_req_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;
  logic        rx_prev_q, tx_prev_q, err_prev_q;

  logic        rx_rise, tx_rise, err_rise;
  logic        stop_any, is_access, acc_done, consume;
  logic [7:0]  rd_fix;

  assign rx_rise   = rx_data_int & ~rx_prev_q;
  assign tx_rise   = tx_done_int & ~tx_prev_q;
  assign err_rise  = rx_error_int & ~err_prev_q;
  assign stop_any  = stop | stop_req_q;
  assign is_access = state_q inside {ST_CFG_CTRL, ST_CFG_INT, ST_RD_RX,
                                     ST_WR_SEND, ST_START, ST_CLR_START};
  assign acc_done  = is_access && (cnt_q == ACC_GAP);

  // Received byte as it will be echoed (optionally upper-cased).
  always_comb begin
    rd_fix = read_data;
`ifdef UART_ECHO_UPCASE_EN
    if (read_data >= 8'h61 && read_data <= 8'h7A) rd_fix[5] = 1'b0;
`endif
  end

  // Sequencer, interrupt bookkeeping and status counters.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    echo_d    = echo_q;
    errc_d    = errc_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    consume   = 1'b0;
    if (is_access) cnt_d = cnt_q + 12'd1;
    case (state_q)
      ST_IDLE: begin
        if (go && !stop) begin
          state_d   = ST_CFG_CTRL;
          overrun_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_CFG_CTRL:  if (acc_done) state_d = stop_any ? ST_IDLE : ST_CFG_INT;
      ST_CFG_INT:   if (acc_done) state_d = stop_any ? ST_IDLE : ST_WAIT_RX;
      ST_RD_RX: begin
        if (cnt_q == ACC_LAST) byte_d = rd_fix;
        if (acc_done) state_d = stop_any ? ST_IDLE : ST_WR_SEND;
      end
      ST_WR_SEND:   if (acc_done) state_d = stop_any ? ST_IDLE : ST_START;
      ST_START:     if (acc_done) state_d = stop_any ? ST_IDLE : ST_CLR_START;
      ST_CLR_START: if (acc_done) state_d = stop_any ? ST_IDLE : ST_WAIT_TX;
      ST_WAIT_RX: begin
        if (stop_any) begin
          state_d = ST_IDLE;
        end else if (pending_q) begin
          state_d = ST_RD_RX;
          consume = 1'b1;
        end
      end
      ST_WAIT_TX: begin
        cnt_d = cnt_q + 12'd1;
        if (stop_any) begin
          state_d = ST_IDLE;
        end else if (tx_rise) begin
          echo_d  = echo_q + 8'd1;
          state_d = ST_WAIT_RX;
        end else if (cnt_q == TMO_LIM) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_RX;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // A rise on the clock that consumes the pending byte becomes the next pending byte.
    pending_d = consume ? rx_rise : (pending_q | rx_rise);
    if (rx_rise && pending_q && !consume) overrun_d = 1'b1;
    if (err_rise && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
    stop_req_d = (state_d != ST_IDLE) && stop_any;
  end

  // Bus drive: registered state decoded; all zero outside the held access clocks.
  always_comb begin
    enable       = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    write_data   = '0;
    if (is_access && cnt_q < ACC_GAP) begin
      enable = 1'b1;
      case (state_q)
        ST_CFG_CTRL:  begin write_enable = 1'b1; address = A_CTRL;    write_data = CTRL_CFG;   end
        ST_CFG_INT:   begin write_enable = 1'b1; address = A_CTRL_IN; write_data = INT_CFG;    end
        ST_RD_RX:     address = A_RECV;
        ST_WR_SEND:   begin write_enable = 1'b1; address = A_SEND;    write_data = byte_q;     end
        ST_START:     begin write_enable = 1'b1; address = A_CTRL;    write_data = CTRL_START; end
        ST_CLR_START: begin write_enable = 1'b1; address = A_CTRL;    write_data = CTRL_CFG;   end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign echo_count = echo_q;
  assign err_count  = errc_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      echo_q     <= '0;
      errc_q     <= '0;
      pending_q  <= 1'b0;
      stop_req_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      rx_prev_q  <= 1'b0;
      tx_prev_q  <= 1'b0;
      err_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      echo_q     <= echo_d;
      errc_q     <= errc_d;
      pending_q  <= pending_d;
      stop_req_q <= stop_req_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      rx_prev_q  <= rx_data_int;
      tx_prev_q  <= tx_done_int;
      err_prev_q <= rx_error_int;
    end
  end

endmodule
